// File: rtl/load_store_unit.sv
// Load/store unit: takes one load/store request at a time from the execute
// stage and turns it into word-aligned accesses on a big-endian byte memory
// port. Sub-word loads are extracted and extended. Sub-word stores are done
// as a read-modify-write of the whole word. Each request ends in a one-cycle
// response that carries either data or an error.
module load_store_unit #(
    parameter int READ_LATENCY = 2,
    parameter int DONE_TIMEOUT = 64,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_address,
    output logic [1:0]  mem_write,
    output logic [7:0]  mem_d0,
    output logic [7:0]  mem_d1,
    output logic [7:0]  mem_d2,
    output logic [7:0]  mem_d3,
    input  logic [7:0]  mem_q0,
    input  logic [7:0]  mem_q1,
    input  logic [7:0]  mem_q2,
    input  logic [7:0]  mem_q3,
    input  logic        mem_done,
    input  logic        mem_error
);

    localparam int RL_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int TO_W = $clog2(DONE_TIMEOUT + 1);
    localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_LOAD_WAIT     = 3'd1,
        ST_RMW_READ      = 3'd2,
        ST_STORE_WRITE   = 3'd3,
        ST_STORE_RELEASE = 3'd4,
        ST_RESP          = 3'd5
    } state_t;

    state_t      state_r;
    logic [DR_W-1:0] drain_r;
    logic [RL_W-1:0] rd_cnt_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [1:0]  lane_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [15:0] wdata_r;
    logic        err_acc_r;

    logic        accept_s;
    logic        rd_last_s;
    logic        to_last_s;
    logic        mem_err_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic [31:0] load_data_s;
    logic [31:0] merge_s;

    // Misaligned or illegal-size requests never touch memory.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lo[0];
            2'd2:    bad = (addr_lo != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign accept_s  = (state_r == ST_IDLE) && req_valid && req_ready;
    assign rd_last_s = (rd_cnt_r == RL_W'(READ_LATENCY - 1));
    assign to_last_s = (to_cnt_r == TO_W'(DONE_TIMEOUT - 1));
    assign mem_err_s = err_acc_r | mem_error;

    // Extract the addressed byte/half from the read word and extend it.
    always_comb begin
        byte_s      = 8'd0;
        half_s      = 16'd0;
        load_data_s = 32'd0;
        case (lane_r)
            2'd0:    byte_s = mem_q0;
            2'd1:    byte_s = mem_q1;
            2'd2:    byte_s = mem_q2;
            default: byte_s = mem_q3;
        endcase
        half_s = lane_r[1] ? {mem_q2, mem_q3} : {mem_q0, mem_q1};
        case (size_r)
            2'd0:    load_data_s = uns_r ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            2'd1:    load_data_s = uns_r ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            2'd2:    load_data_s = {mem_q0, mem_q1, mem_q2, mem_q3};
            default: load_data_s = 32'd0;
        endcase
    end

    // Merge sub-word store data into the word read back from memory
    // (byte offset 0 is the most significant byte).
    always_comb begin
        merge_s = {mem_q0, mem_q1, mem_q2, mem_q3};
        case (size_r)
            2'd0: merge_s[(5'd3 - {3'd0, lane_r}) * 5'd8 +: 8] = wdata_r[7:0];
            2'd1: begin
                if (lane_r[1]) begin
                    merge_s[15:0] = wdata_r;
                end else begin
                    merge_s[31:16] = wdata_r;
                end
            end
            default: merge_s = {mem_q0, mem_q1, mem_q2, mem_q3};
        endcase
    end

    // Request/memory sequencing FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            drain_r     <= DR_W'(DRAIN_CYCLES);
            rd_cnt_r    <= '0;
            to_cnt_r    <= '0;
            lane_r      <= 2'd0;
            size_r      <= 2'd0;
            uns_r       <= 1'b0;
            wdata_r     <= 16'd0;
            err_acc_r   <= 1'b0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= 32'd0;
            resp_error  <= 1'b0;
            mem_address <= 32'd0;
            mem_write   <= 2'd0;
            mem_d0      <= 8'd0;
            mem_d1      <= 8'd0;
            mem_d2      <= 8'd0;
            mem_d3      <= 8'd0;
        end else begin
            resp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (drain_r != DR_W'(0)) begin
                        drain_r   <= drain_r - DR_W'(1);
                        req_ready <= (drain_r == DR_W'(1));
                    end else begin
                        req_ready <= ~accept_s;
                    end
                    if (accept_s) begin
                        lane_r      <= req_addr[1:0];
                        size_r      <= req_size;
                        uns_r       <= req_unsigned;
                        wdata_r     <= req_wdata[15:0];
                        err_acc_r   <= 1'b0;
                        rd_cnt_r    <= '0;
                        to_cnt_r    <= '0;
                        mem_address <= {req_addr[31:2], 2'b00};
                        if (misaligned(req_size, req_addr[1:0])) begin
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'd0;
                            state_r    <= ST_RESP;
                        end else if (!req_store) begin
                            state_r <= ST_LOAD_WAIT;
                        end else if (req_size == 2'd2) begin
                            mem_d0    <= req_wdata[31:24];
                            mem_d1    <= req_wdata[23:16];
                            mem_d2    <= req_wdata[15:8];
                            mem_d3    <= req_wdata[7:0];
                            mem_write <= 2'd3;
                            state_r   <= ST_STORE_WRITE;
                        end else begin
                            state_r <= ST_RMW_READ;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOAD_WAIT: begin
                    err_acc_r <= mem_err_s;
                    if (rd_last_s) begin
                        resp_valid <= 1'b1;
                        resp_error <= mem_err_s;
                        resp_rdata <= mem_err_s ? 32'd0 : load_data_s;
                        state_r    <= ST_RESP;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + RL_W'(1);
                    end
                end
                ST_RMW_READ: begin
                    err_acc_r <= mem_err_s;
                    if (rd_last_s) begin
                        mem_d0    <= merge_s[31:24];
                        mem_d1    <= merge_s[23:16];
                        mem_d2    <= merge_s[15:8];
                        mem_d3    <= merge_s[7:0];
                        mem_write <= 2'd3;
                        to_cnt_r  <= '0;
                        state_r   <= ST_STORE_WRITE;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + RL_W'(1);
                    end
                end
                ST_STORE_WRITE: begin
                    err_acc_r <= mem_err_s;
                    if (mem_done) begin
                        mem_write <= 2'd0;
                        to_cnt_r  <= '0;
                        state_r   <= ST_STORE_RELEASE;
                    end else if (to_last_s) begin
                        mem_write  <= 2'd0;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= 32'd0;
                        state_r    <= ST_RESP;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_STORE_RELEASE: begin
                    err_acc_r <= mem_err_s;
                    mem_write <= 2'd0;
                    if (!mem_done) begin
                        resp_valid <= 1'b1;
                        resp_error <= mem_err_s;
                        resp_rdata <= 32'd0;
                        state_r    <= ST_RESP;
                    end else if (to_last_s) begin
                        resp_valid <= 1'b1;
                        resp_error <= 1'b1;
                        resp_rdata <= 32'd0;
                        state_r    <= ST_RESP;
                    end else begin
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_RESP: begin
                    req_ready <= (drain_r == DR_W'(0));
                    state_r   <= ST_IDLE;
                end
                default: begin
                    mem_write <= 2'd0;
                    req_ready <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sits between the execute stage and byte_addressable. Accepts one load/store request at a time over a valid/ready handshake and issues word-aligned accesses to the memory port. Extracts and extends sub-word load data. Performs sub-word stores as read-modify-write of a full word, and returns a single-cycle response with data or error.

Parameters:
READ_LATENCY, 2, cycles mem_address must be held before mem_q0..mem_q3 are valid (synchronous RAM read).
DONE_TIMEOUT, 64, max cycles spent waiting on mem_done (assert or release) before aborting with error.
DRAIN_CYCLES, 8, cycles req_ready is held low after reset so the memory FSM can return to START.

Ports:
clk  in  1  system clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept; high only in IDLE when drain counter is 0.
req_store  in  1  1 = store, 0 = load.
req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal and raises error.
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified for byte and half.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  load result; 0 for stores and errors.
resp_error  out  1  misaligned, illegal size, mem_error, or timeout.
mem_address  out  32  always {addr[31:2],2'b00}.
mem_write  out  2  0 = idle, 3 = word write; no other values are driven.
mem_d0..mem_d3  out  8 each  write bytes; d0 = byte offset 0 = word bits 31:24 (big-endian).
mem_q0..mem_q3  in  8 each  read bytes, same ordering.
mem_done  in  1  memory write complete.
mem_error  in  1  memory alignment error.

Behaviour:
- Reset: state=IDLE, req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0, mem_write=0, mem_address=0, mem_d*=0, drain counter=DRAIN_CYCLES.
- Drain: the counter decrements each cycle in IDLE; req_ready=1 once it reaches 0.
- Handshake: accept when req_valid&req_ready. Register addr, size, store, unsigned and wdata. req_ready drops the next cycle.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or size=3. Next state is RESP with error=1. No memory activity; mem_write stays 0.
- States: IDLE, LOAD_WAIT, RMW_READ, STORE_WRITE, STORE_RELEASE, RESP.
- LOAD_WAIT: drive mem_address for READ_LATENCY cycles. On the last cycle, capture the bytes and mem_error, then go to RESP. Load latency = READ_LATENCY+1 cycles from accept to resp_valid.
- Load extract, with k = addr[1:0]:
  - byte: returns q_k.
  - half: k=0 gives {q0,q1}; k=2 gives {q2,q3}.
  - word: {q0,q1,q2,q3}.
  - Extend to 32 bits per req_unsigned.
- Word store: IDLE goes directly to STORE_WRITE with d0..d3 = wdata[31:24]..wdata[7:0].
- Byte/half store: RMW_READ for READ_LATENCY cycles, then merge wdata[7:0] or wdata[15:0] into the target byte lane(s) of the read word, then STORE_WRITE.
- STORE_WRITE:
  - mem_write=3, with mem_address and mem_d* held stable.
  - On mem_done=1: mem_write=0 the next cycle, enter STORE_RELEASE.
- STORE_RELEASE: mem_write=0. When mem_done=0, go to RESP.
- Timeout: a cycle counter resets on entry to STORE_WRITE and again on entry to STORE_RELEASE. Reaching DONE_TIMEOUT in either state forces mem_write=0 and goes to RESP with error=1.
- mem_error: if sampled high on any cycle the access is active, it is OR-ed into resp_error.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata/resp_error are held until the next RESP.
- Simultaneous events: req_valid is ignored outside IDLE. A new request may be accepted the cycle after RESP.
- Reset mid-operation: mem_write=0 the next cycle; the in-flight store may or may not commit; no resp_valid is issued for it. The drain counter reloads.

Test Plan:
- Reset, then wait: req_ready=0 for 8 cycles and 1 on cycle 9; all outputs 0 throughout.
- Store word 0x11223344 @0x40, then load word @0x40 -> resp_rdata=0x11223344, error=0. Load resp_valid arrives exactly 3 cycles after accept.
- With 0x40 = 0x11223344: store byte 0xAA @0x42 -> memory word 0x1122AA44. Then load byte signed @0x42 -> 0xFFFFFFAA; load byte unsigned -> 0x000000AA; load half @0x42 signed -> 0xFFFFAA44.
- Load half @0x41 and store word @0x46 -> resp_valid at accept+1, error=1, rdata=0, mem_write never nonzero.
- Memory model holds mem_done=0 forever on a word store -> resp_valid with error=1 after 64 cycles, mem_write=0 afterwards.
- rst asserted on the 2nd cycle of STORE_WRITE -> mem_write=0 the next cycle, no resp_valid, req_ready low for 8 cycles then high.
